branch_ctrl: RTL and testbench

Branch resolution and redirect generator for the single-cycle/pipelined LEGv8 core. It accepts decoded-stage instructions over a valid/ready handshake and keeps the architectural NZCV flag register. It evaluates B, BL, B.cond, CBZ, CBNZ and, optionally, BR. It drives the registered redirect controls consumed by the program counter (BrTaken, UncondBr, CondAddr19, BrAddr26, pc_rd, pc_ext) and squashes wrong-path instructions after every taken branch.

---
 rtl/branch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution and PC redirect for the LEGv8 core; optional BR support under `define BR_REG_EN.
// Latency: redirect outputs are registered, one cycle after acceptance. Backpressure: instr_ready is high whenever reset is released.
module branch_ctrl #(
    parameter int FLUSH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic [63:0] instr_pc,
    input  logic        rt_zero,
    input  logic [63:0] rn_data,
    input  logic        flag_we,
    input  logic [3:0]  flags_in,
    output logic [3:0]  flags,
    output logic        BrTaken,
    output logic        UncondBr,
    output logic [18:0] CondAddr19,
    output logic [25:0] BrAddr26,
    output logic        pc_rd,
    output logic [63:0] pc_ext,
    output logic        link_we,
    output logic [63:0] link_data,
    output logic        squash
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] SLOTS = 3'(FLUSH_SLOTS);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [3:0]  flags_q, flags_d;
    logic        br_taken_q, br_taken_d;
    logic        uncond_q, uncond_d;
    logic [18:0] cond_addr_q, cond_addr_d;
    logic [25:0] br_addr_q, br_addr_d;
    logic        link_we_q, link_we_d;
    logic [63:0] link_data_q, link_data_d;
    logic        pc_rd_q, pc_rd_d;
    logic [63:0] pc_ext_q, pc_ext_d;

    logic        accept, is_b, is_bl, is_bcond, is_cbz, is_cbnz, is_br;
    logic        take_uncond, take_cond, cond_true;
    logic [3:0]  eff_flags;

    // Flags are {N,Z,C,V}; odd codes invert the even base, except 1111 which is AL.
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic r;
        case (c[3:1])
            3'd0:    r = f[2];
            3'd1:    r = f[1];
            3'd2:    r = f[3];
            3'd3:    r = f[0];
            3'd4:    r = f[1] & ~f[2];
            3'd5:    r = (f[3] == f[0]);
            3'd6:    r = ~f[2] & (f[3] == f[0]);
            default: r = 1'b1;
        endcase
        if (c[0] && (c[3:1] != 3'b111)) r = ~r;
        return r;
    endfunction

    assign instr_ready = reset;
    assign accept      = instr_valid & instr_ready;
    assign squash      = accept & (state_q == FLUSH);
    assign eff_flags   = flag_we ? flags_in : flags_q;

    assign is_b     = (instr[31:26] == 6'b000101);
    assign is_bl    = (instr[31:26] == 6'b100101);
    assign is_bcond = (instr[31:24] == 8'b01010100);
    assign is_cbz   = (instr[31:24] == 8'b10110100);
    assign is_cbnz  = (instr[31:24] == 8'b10110101);
`ifdef BR_REG_EN
    assign is_br    = (instr[31:21] == 11'b11010110000);
`else
    assign is_br    = 1'b0;
    logic unused_rn;
    assign unused_rn = ^rn_data;
`endif

    assign cond_true   = cond_eval(instr[3:0], eff_flags);
    assign take_uncond = is_b | is_bl;
    assign take_cond   = (is_bcond & cond_true) | (is_cbz & rt_zero) | (is_cbnz & ~rt_zero);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flags_d     = flag_we ? flags_in : flags_q;
        br_taken_d  = 1'b0;
        link_we_d   = 1'b0;
        pc_rd_d     = 1'b0;
        uncond_d    = uncond_q;
        cond_addr_d = cond_addr_q;
        br_addr_d   = br_addr_q;
        link_data_d = link_data_q;
        pc_ext_d    = pc_ext_q;
        if (accept && state_q == RUN) begin
            if (take_uncond) begin
                br_taken_d = 1'b1;
                uncond_d   = 1'b1;
                br_addr_d  = instr[25:0];
                if (is_bl) begin
                    link_we_d   = 1'b1;
                    link_data_d = instr_pc + 64'd4;
                end
            end else if (take_cond) begin
                br_taken_d  = 1'b1;
                uncond_d    = 1'b0;
                cond_addr_d = instr[23:5];
            end else if (is_br) begin
                pc_rd_d  = 1'b1;
                pc_ext_d = rn_data;
            end
            if (take_uncond || take_cond || is_br) begin
                state_d = FLUSH;
                cnt_d   = SLOTS;
            end
        end else if (accept && state_q == FLUSH) begin
            // Only accepted instructions consume a slot; bubbles leave cnt alone.
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= 3'd0;
            flags_q     <= 4'd0;
            br_taken_q  <= 1'b0;
            uncond_q    <= 1'b0;
            cond_addr_q <= 19'd0;
            br_addr_q   <= 26'd0;
            link_we_q   <= 1'b0;
            link_data_q <= 64'd0;
            pc_rd_q     <= 1'b0;
            pc_ext_q    <= 64'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            uncond_q    <= uncond_d;
            cond_addr_q <= cond_addr_d;
            br_addr_q   <= br_addr_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
            pc_rd_q     <= pc_rd_d;
            pc_ext_q    <= pc_ext_d;
        end
    end

    assign flags      = flags_q;
    assign BrTaken    = br_taken_q;
    assign UncondBr   = uncond_q;
    assign CondAddr19 = cond_addr_q;
    assign BrAddr26   = br_addr_q;
    assign link_we    = link_we_q;
    assign link_data  = link_data_q;
`ifdef BR_REG_EN
    assign pc_rd      = pc_rd_q;
    assign pc_ext     = pc_ext_q;
`else
    assign pc_rd      = 1'b0;
    assign pc_ext     = 64'd0;
    logic unused_br;
    assign unused_br = pc_rd_q ^ (^pc_ext_q);
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed table-driven bench for branch_ctrl plus hand-written flush/reset sequences.
module tb_branch_ctrl;

    localparam int SLOTS = 2;
`ifdef BR_REG_EN
    localparam logic        BRE = 1'b1;
    localparam logic [63:0] P6  = 64'd45826;
`else
    localparam logic        BRE = 1'b0;
    localparam logic [63:0] P6  = 64'd0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic [63:0] instr_pc = 64'd0;
    logic        rt_zero = 1'b0;
    logic [63:0] rn_data = 64'd0;
    logic        flag_we = 1'b0;
    logic [3:0]  flags_in = 4'd0;
    logic [3:0]  flags;
    logic        BrTaken, UncondBr, pc_rd, link_we, squash;
    logic [18:0] CondAddr19;
    logic [25:0] BrAddr26;
    logic [63:0] pc_ext, link_data;

    int n_err = 0;
    int n_chk = 0;
    logic sq_s;

    branch_ctrl #(.FLUSH_SLOTS(SLOTS)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .rt_zero(rt_zero), .rn_data(rn_data),
        .flag_we(flag_we), .flags_in(flags_in), .flags(flags), .BrTaken(BrTaken),
        .UncondBr(UncondBr), .CondAddr19(CondAddr19), .BrAddr26(BrAddr26),
        .pc_rd(pc_rd), .pc_ext(pc_ext), .link_we(link_we), .link_data(link_data),
        .squash(squash)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        rz;
        logic [63:0] rn;
        logic        fwe;
        logic [3:0]  fin;
        logic        taken;
        logic        unc;
        logic [18:0] c19;
        logic [25:0] a26;
        logic        prd;
        logic [63:0] pext;
        logic        lwe;
        logic [63:0] ldat;
        logic [3:0]  flg;
        logic        flush;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] mk_b(input logic [5:0] op, input logic [25:0] imm);
        return {op, imm};
    endfunction
    function automatic logic [31:0] mk_bc(input logic [3:0] c, input logic [18:0] imm);
        return {8'h54, imm, 1'b0, c};
    endfunction
    function automatic logic [31:0] mk_cb(input logic [7:0] op, input logic [18:0] imm);
        return {op, imm, 5'd3};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [63:0] pc, input logic rz,
                         input logic [63:0] rn, input logic fwe, input logic [3:0] fin);
        @(negedge clk);
        instr = i; instr_pc = pc; rt_zero = rz; rn_data = rn;
        flag_we = fwe; flags_in = fin; instr_valid = 1'b1;
        #1 sq_s = squash;
        @(posedge clk);
        #1;
        instr_valid = 1'b0; flag_we = 1'b0; instr = 32'd0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic filler(input logic fwe, input logic [3:0] fin);
        drive(mk_b(6'b100101, 26'd12), 64'h1000, 1'b0, 64'd0, fwe, fin);
        chk("flush_squash", 64'(sq_s), 64'd1);
        chk("flush_brtaken", 64'(BrTaken), 64'd0);
        chk("flush_link_we", 64'(link_we), 64'd0);
        chk("flush_pc_rd", 64'(pc_rd), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{mk_b(6'b000101, 26'd328), 64'h100, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b1, 1'b1, 19'd0, 26'd328, 1'b0, 64'd0, 1'b0, 64'd0, 4'h0, 1'b1};
        vecs[1]  = '{mk_b(6'b100101, 26'd4), 64'h40, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b1, 1'b1, 19'd0, 26'd4, 1'b0, 64'd0, 1'b1, 64'h44, 4'h0, 1'b1};
        vecs[2]  = '{mk_bc(4'h0, 19'd164), 64'h80, 1'b0, 64'd0, 1'b1, 4'b0100,
                     1'b1, 1'b0, 19'd164, 26'd4, 1'b0, 64'd0, 1'b0, 64'd0, 4'h4, 1'b1};
        vecs[3]  = '{mk_bc(4'h1, 19'd200), 64'h84, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b0, 1'b0, 19'd164, 26'd4, 1'b0, 64'd0, 1'b0, 64'd0, 4'h4, 1'b0};
        vecs[4]  = '{mk_cb(8'hB4, 19'd77), 64'h88, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b0, 1'b0, 19'd164, 26'd4, 1'b0, 64'd0, 1'b0, 64'd0, 4'h4, 1'b0};
        vecs[5]  = '{mk_cb(8'hB5, 19'd77), 64'h8C, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b1, 1'b0, 19'd77, 26'd4, 1'b0, 64'd0, 1'b0, 64'd0, 4'h4, 1'b1};
        vecs[6]  = '{32'hD61F0020, 64'h200, 1'b0, 64'd45826, 1'b0, 4'h0,
                     1'b0, 1'b0, 19'd77, 26'd4, BRE, P6, 1'b0, 64'd0, 4'h4, BRE};
        vecs[7]  = '{mk_bc(4'hA, 19'd5), 64'h204, 1'b0, 64'd0, 1'b1, 4'b1001,
                     1'b1, 1'b0, 19'd5, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h9, 1'b1};
        vecs[8]  = '{mk_bc(4'hB, 19'd6), 64'h208, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b0, 1'b0, 19'd5, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h9, 1'b0};
        vecs[9]  = '{mk_bc(4'h8, 19'd9), 64'h20C, 1'b0, 64'd0, 1'b1, 4'b0010,
                     1'b1, 1'b0, 19'd9, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h2, 1'b1};
        vecs[10] = '{mk_bc(4'h9, 19'd10), 64'h210, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b0, 1'b0, 19'd9, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h2, 1'b0};
        vecs[11] = '{32'h8B020020, 64'h214, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b0, 1'b0, 19'd9, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h2, 1'b0};
        vecs[12] = '{mk_bc(4'hE, 19'd3), 64'h218, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b1, 1'b0, 19'd3, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h2, 1'b1};
        vecs[13] = '{mk_cb(8'hB4, 19'h7FFFF), 64'h21C, 1'b1, 64'd0, 1'b0, 4'h0,
                     1'b1, 1'b0, 19'h7FFFF, 26'd4, 1'b0, P6, 1'b0, 64'd0, 4'h2, 1'b1};
        vecs[14] = '{mk_b(6'b100101, 26'h3FFFFFF), 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 1'b0, 4'h0,
                     1'b1, 1'b1, 19'h7FFFF, 26'h3FFFFFF, 1'b0, P6, 1'b1, 64'd0, 4'h2, 1'b1};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 64'(instr_ready), 64'd0);
        chk("rst_brtaken", 64'(BrTaken), 64'd0);
        chk("rst_flags", 64'(flags), 64'd0);
        chk("rst_link_data", link_data, 64'd0);
        chk("rst_pc_ext", pc_ext, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("run_ready", 64'(instr_ready), 64'd1);
        chk("idle_squash", 64'(squash), 64'd0);

        for (int k = 0; k < 15; k++) begin
            drive(vecs[k].instr, vecs[k].pc, vecs[k].rz, vecs[k].rn, vecs[k].fwe, vecs[k].fin);
            chk($sformatf("v%0d_squash", k), 64'(sq_s), 64'd0);
            chk($sformatf("v%0d_brtaken", k), 64'(BrTaken), 64'(vecs[k].taken));
            if (vecs[k].taken) chk($sformatf("v%0d_uncond", k), 64'(UncondBr), 64'(vecs[k].unc));
            chk($sformatf("v%0d_cond19", k), 64'(CondAddr19), 64'(vecs[k].c19));
            chk($sformatf("v%0d_addr26", k), 64'(BrAddr26), 64'(vecs[k].a26));
            chk($sformatf("v%0d_pc_rd", k), 64'(pc_rd), 64'(vecs[k].prd));
            chk($sformatf("v%0d_pc_ext", k), pc_ext, vecs[k].pext);
            chk($sformatf("v%0d_link_we", k), 64'(link_we), 64'(vecs[k].lwe));
            if (vecs[k].lwe) chk($sformatf("v%0d_link_data", k), link_data, vecs[k].ldat);
            chk($sformatf("v%0d_flags", k), 64'(flags), 64'(vecs[k].flg));
            if (vecs[k].flush) begin
                for (int s = 0; s < SLOTS; s++) filler(1'b0, 4'h0);
            end
        end

        // Bubbles in FLUSH keep the slot count; flag writes land during FLUSH.
        drive(mk_b(6'b000101, 26'd8), 64'h300, 1'b0, 64'd0, 1'b0, 4'h0);
        chk("seqA_brtaken", 64'(BrTaken), 64'd1);
        idle();
        chk("seqA_pulse_one_cycle", 64'(BrTaken), 64'd0);
        idle();
        idle();
        for (int s = 0; s < SLOTS; s++) filler(s == 0, 4'b0100);
        chk("seqA_flags_in_flush", 64'(flags), 64'h4);
        drive(mk_bc(4'h0, 19'd11), 64'h310, 1'b0, 64'd0, 1'b0, 4'h0);
        chk("seqA_after_squash", 64'(sq_s), 64'd0);
        chk("seqA_beq_taken", 64'(BrTaken), 64'd1);
        chk("seqA_beq_cond19", 64'(CondAddr19), 64'd11);
        for (int s = 0; s < SLOTS; s++) filler(1'b0, 4'h0);

        // Reset in the first flush slot returns to RUN.
        drive(mk_b(6'b000101, 26'd16), 64'h400, 1'b0, 64'd0, 1'b0, 4'h0);
        chk("seqB_brtaken", 64'(BrTaken), 64'd1);
        filler(1'b0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("seqB_rst_brtaken", 64'(BrTaken), 64'd0);
        chk("seqB_rst_flags", 64'(flags), 64'd0);
        chk("seqB_rst_cond19", 64'(CondAddr19), 64'd0);
        chk("seqB_rst_addr26", 64'(BrAddr26), 64'd0);
        chk("seqB_rst_ready", 64'(instr_ready), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(mk_bc(4'hE, 19'd21), 64'h500, 1'b0, 64'd0, 1'b0, 4'h0);
        chk("seqB_bal_squash", 64'(sq_s), 64'd0);
        chk("seqB_bal_taken", 64'(BrTaken), 64'd1);
        chk("seqB_bal_uncond", 64'(UncondBr), 64'd0);
        chk("seqB_bal_cond19", 64'(CondAddr19), 64'd21);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
